// File: rtl/swr_pkg.sv
// swr_pkg: shared FSM states, buffer depth and bit-count width for the serial word receiver.
package swr_pkg;
  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef SWR_PARITY_EN
    , PARITY
`endif
  } state_e;
  localparam int BUF_DEPTH = 2;
  function automatic int cnt_width(int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/serial_word_receiver_if.sv
// serial_word_receiver_if: serial input strobes plus ready/valid word output and status flags.
interface serial_word_receiver_if #(parameter int WIDTH = 64);
  logic             sin_valid;
  logic             sin_data;
  logic             sin_start;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             busy;
  logic             overflow;
  logic             parity_err;
  modport master (output sin_valid, sin_data, sin_start, dout_ready,
                  input dout, dout_valid, busy, overflow, parity_err);
  modport slave (input sin_valid, sin_data, sin_start, dout_ready,
                 output dout, dout_valid, busy, overflow, parity_err);
endinterface

// File: rtl/swr_out_buf.sv
// swr_out_buf: 2-entry ready/valid FIFO; a push into a full buffer lands only if a pop frees a slot that cycle.
module swr_out_buf
  import swr_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             pop, wr;
  assign full_o  = cnt_q == CW'(BUF_DEPTH);
  assign valid_o = cnt_q != '0;
  assign data_o  = mem_q[rd_q];
  assign pop     = valid_o & ready_i;
  assign wr      = push_i & (!full_o | pop);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr) mem_q[wr_q] <= data_i;
      wr_q  <= wr_q + PW'(wr);
      rd_q  <= rd_q + PW'(pop);
      cnt_q <= cnt_q + CW'(wr) - CW'(pop);
    end
  end
endmodule

// File: rtl/serial_word_receiver.sv
// serial_word_receiver: MSB-first framed serial-to-parallel receiver; SWR_PARITY_EN adds an even-parity bit per frame.
module serial_word_receiver
  import swr_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input logic                   clk,
  input logic                   rst,
  serial_word_receiver_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);
`ifdef SWR_PARITY_EN
  localparam int SW = WIDTH;
`else
  localparam int SW = WIDTH - 1;
`endif
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    sh_q, sh_d;
  logic [WIDTH-1:0] word;
  logic             commit, full, last, ovf_q;
  assign last     = cnt_q == CW'(WIDTH - 1);
  assign bus.busy = state_q != IDLE;
`ifdef SWR_PARITY_EN
  logic bad, perr_q;
  assign word           = sh_q;
  assign bad            = ^sh_q ^ bus.sin_data;
  assign bus.parity_err = perr_q;
`else
  assign word           = {sh_q, bus.sin_data};
  assign bus.parity_err = 1'b0;
`endif
  assign bus.overflow = ovf_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    commit  = 1'b0;
    if (bus.sin_valid) begin
      if (bus.sin_start) begin
        sh_d    = SW'(bus.sin_data);
        cnt_d   = CW'(1);
        state_d = SHIFT;
      end else if (state_q == SHIFT) begin
        sh_d  = SW'({sh_q, bus.sin_data});
        cnt_d = last ? '0 : cnt_q + CW'(1);
`ifdef SWR_PARITY_EN
        state_d = last ? PARITY : SHIFT;
      end else if (state_q == PARITY) begin
        state_d = IDLE;
        commit  = !bad;
`else
        state_d = last ? IDLE : SHIFT;
        commit  = last;
`endif
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ovf_q   <= ovf_q | (commit & full & !(bus.dout_valid & bus.dout_ready));
    end
  end
`ifdef SWR_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perr_q <= 1'b0;
    else perr_q <= perr_q | (bus.sin_valid & !bus.sin_start & state_q == PARITY & bad);
  end
`endif
  swr_out_buf #(.WIDTH(WIDTH)) u_buf (
    .clk    (clk),
    .rst    (rst),
    .push_i (commit),
    .data_i (word),
    .full_o (full),
    .valid_o(bus.dout_valid),
    .ready_i(bus.dout_ready),
    .data_o (bus.dout)
  );
endmodule

// File: doc/serial_word_receiver.md
# serial_word_receiver

- Serial-to-parallel receiver: assembles a framed, MSB-first serial bit stream into WIDTH-bit words.
- Presents each word on a ready/valid output backed by a 2-entry buffer.
- Forms the receive end of the word-serial link; its words feed the parallel-load register stage downstream.

## Interface
Parameters:
- WIDTH, 64, data bits per word (≥ 2)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- sin_valid  in  1  bit strobe; sin_data/sin_start sampled only when high
- sin_data  in  1  serial data bit
- sin_start  in  1  frame start; qualifies the bit carried on the same strobe as the first (MSB) bit
- dout  out  WIDTH  received word (head of buffer)
- dout_valid  out  1  dout holds a word
- dout_ready  in  1  consumer accepts dout this cycle
- busy  out  1  frame in progress (state ≠ IDLE)
- overflow  out  1  sticky; a completed word was dropped because the buffer was full
- parity_err  out  1  sticky; a word failed parity (always 0 without SWR_PARITY_EN)

## Operation
- FSM states: IDLE, SHIFT, PARITY (PARITY exists only with SWR_PARITY_EN).
- IDLE:
  - sin_valid & sin_start → shift in bit, bit count = 1, go to SHIFT.
  - sin_valid without sin_start → bit ignored.
- SHIFT, per strobe:
  - Shift left; new bit enters the LSB. Bit count increments.
  - The strobe that brings the count to WIDTH completes the word → commit, then IDLE (or PARITY if enabled).
  - sin_start on any strobe → abort the partial word silently; the bit becomes bit 1 of a new frame; stay in SHIFT.
- PARITY (with SWR_PARITY_EN):
  - Next strobe carries the even-parity bit.
  - XOR of the WIDTH data bits and the parity bit = 0 → commit.
  - Otherwise → drop the word, set parity_err.
  - Go to IDLE in both cases. A sin_start here aborts the frame as in SHIFT.
- Commit:
  - Buffer has a free slot → write the word.
  - Buffer full and no pop this cycle → drop the word, set overflow.
  - Buffer full and a pop this same cycle → write accepted.
- Output:
  - dout_valid = buffer not empty.
  - Pop on dout_valid & dout_ready.
  - dout is stable while dout_valid & !dout_ready.
  - Words leave in commit order.
- Reset values: dout = 0, dout_valid = 0, busy = 0, overflow = 0, parity_err = 0; FSM in IDLE, bit count 0, buffer empty.
- Sticky flags clear only on rst.
- rst mid-frame discards the partial word and all buffered words immediately (asynchronous).

## Timing
- Strobes may arrive on consecutive cycles; there is no minimum gap.
- Commit happens on the edge that samples the final bit (the last data bit, or the parity bit when enabled).
- dout_valid is high in the cycle following that edge: 1-cycle latency.
- Throughput: one word per WIDTH strobes (WIDTH+1 with parity).
- A pop happens on the edge where dout_valid & dout_ready.
  - The next buffered word appears on dout in the following cycle.
  - No bubble when 2 words are buffered.
- overflow and parity_err rise in the cycle after the offending final-bit edge.
- busy deasserts in the cycle after commit.

## Configuration
- SWR_PARITY_EN defined:
  - PARITY state present; a frame is WIDTH+1 bits; bad-parity words are dropped and flagged on parity_err.
- Undefined:
  - No PARITY state; a frame is WIDTH bits; parity_err is tied 0.
  - The port list is identical in both builds.

## Structure
- Shared package swr_pkg holds:
  - the FSM state enum;
  - the buffer depth constant (2);
  - the bit-count width function, clog2(WIDTH+1).
- Sub-module swr_out_buf: 2-entry ready/valid FIFO with push and a full flag. It is reusable by the transmit side.

## Test plan
WIDTH=8 for all scenarios:
- Basic frame:
  - Stimulus: start + bits 1,0,1,0,0,1,0,1 on consecutive strobes, dout_ready=1.
  - Response: dout=0xA5, dout_valid for exactly 1 cycle, 1 cycle after the 8th bit; busy low afterwards.
- Backpressure:
  - Stimulus: dout_ready=0; send 0x11, 0x22, 0x33.
  - Response: dout holds 0x11; overflow=1 after the third frame.
  - Then raise dout_ready: 0x11 and 0x22 are popped on back-to-back cycles; 0x33 never appears.
- Simultaneous commit and pop with a full buffer:
  - Response: word accepted, overflow stays 0.
- Frame abort:
  - Stimulus: start, 4 bits, then start + 0x3C.
  - Response: only 0x3C is delivered.
- Gapped strobes and reset:
  - Stimulus: strobes with random 0–3 cycle gaps deliver 0xC3; then pulse rst after bit 5 of a new frame.
  - Response: 0xC3 is delivered; after rst all outputs are 0 and no word appears from the aborted frame.
- Parity (SWR_PARITY_EN):
  - Stimulus: 0xA5 with parity 0.
  - Response: delivered.
  - Stimulus: 0xA5 with parity 1.
  - Response: dropped, parity_err=1.
